// File: rtl/spi_frame_sched_if.sv
// Frame-in / symbol-out bus of spi_frame_sched.
// Latency: none (wires only).
// Backpressure: sym_ready from the consumer; frames have none (they are accepted or dropped).
//   frame_valid/frame_data : one-cycle frame pulse from the SPI receive datapath
//   sym_valid/sym_ready    : symbol handshake; sym_data/sym_index/sym_last qualify a symbol
//   master modport = frame source and symbol sink; slave modport = the scheduler
interface spi_frame_sched_if #(
   parameter int DATA_WIDTH = 2,
   parameter int DATA_DEPTH = 16
);
   localparam int IW = $clog2(DATA_DEPTH);

   logic                             frame_valid;
   logic [DATA_WIDTH*DATA_DEPTH-1:0] frame_data;
   logic                             sym_valid;
   logic                             sym_ready;
   logic [DATA_WIDTH-1:0]            sym_data;
   logic [IW-1:0]                    sym_index;
   logic                             sym_last;

   modport master (
      output frame_valid, frame_data, sym_ready,
      input  sym_valid, sym_data, sym_index, sym_last
   );

   modport slave (
      input  frame_valid, frame_data, sym_ready,
      output sym_valid, sym_data, sym_index, sym_last
   );
endinterface

// File: rtl/spi_frame_sched.sv
// Two-frame scheduler: buffers received frames and streams them out MSB symbol first.
// Latency: frame_valid in IDLE -> symbol 0 valid next cycle; back-to-back frames have no bubble.
// Backpressure: symbols hold while sym_ready=0; frames arriving with no buffer space are dropped and counted.
//   clk, nrst          : clock, asynchronous active-low reset
//   bus (slave)        : frame input and symbol output handshake
//   flush, clear_ovf   : synchronous abort of held frames / clear of drop status
//   busy, overflow     : frame held / sticky drop flag
//   drop_count         : saturating drop counter, present only with SPI_FRAME_SCHED_DROP_CNT_EN
module spi_frame_sched #(
   parameter int DATA_WIDTH = 2,
   parameter int DATA_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   spi_frame_sched_if.slave      bus,
   input  logic                  flush,
   input  logic                  clear_ovf,
   output logic                  busy,
   output logic                  overflow,
   output logic [7:0]            drop_count
);
   localparam int FW = DATA_WIDTH * DATA_DEPTH;
   localparam int IW = $clog2(DATA_DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_DEPTH - 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [FW-1:0] act_q, act_d;       // active frame, current symbol kept in the top W bits
   logic [FW-1:0] pend_q, pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          last_q, last_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;
   logic          xfer;
   logic          drop;

   assign xfer = (state_q == ST_STREAM) & bus.sym_ready;

   always_comb begin
      state_d    = state_q;
      act_d      = act_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      idx_d      = idx_q;
      drop       = 1'b0;

      if (flush) begin
         // Held frames are abandoned; a coincident frame is discarded, not dropped.
         state_d    = ST_IDLE;
         pend_vld_d = 1'b0;
         idx_d      = '0;
      end else if (state_q == ST_IDLE) begin
         if (bus.frame_valid) begin
            act_d   = bus.frame_data;
            state_d = ST_STREAM;
            idx_d   = '0;
         end
      end else if (xfer && last_q) begin
         // Frame boundary: the next frame (pending first, else a new arrival) starts with no bubble.
         idx_d = '0;
         if (pend_vld_q) begin
            act_d = pend_q;
            if (bus.frame_valid) begin
               pend_d = bus.frame_data;
            end else begin
               pend_vld_d = 1'b0;
            end
         end else if (bus.frame_valid) begin
            act_d = bus.frame_data;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         if (xfer) begin
            act_d = act_q << DATA_WIDTH;
            idx_d = idx_q + 1'b1;
         end
         if (bus.frame_valid) begin
            if (!pend_vld_q) begin
               pend_d     = bus.frame_data;
               pend_vld_d = 1'b1;
            end else begin
               drop = 1'b1;
            end
         end
      end

      // Registered copies so no output depends combinationally on any input.
      last_d = (state_d == ST_STREAM) && (idx_d == LAST_IDX);
      busy_d = (state_d == ST_STREAM) | pend_vld_d;

      // A drop in the same cycle as clear_ovf leaves the flag set.
      ovf_d = clear_ovf ? 1'b0 : ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= ST_IDLE;
         act_q      <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         idx_q      <= '0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         act_q      <= act_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef SPI_FRAME_SCHED_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = clear_ovf ? 8'd0 : drop_cnt_q;
      if (drop) begin
         if (clear_ovf) begin
            drop_cnt_d = 8'd1;
         end else if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = 8'd0;
`endif

   assign bus.sym_valid = (state_q == ST_STREAM);
   assign bus.sym_data  = act_q[FW-1 -: DATA_WIDTH];
   assign bus.sym_index = idx_q;
   assign bus.sym_last  = last_q;
   assign busy          = busy_q;
   assign overflow      = ovf_q;
endmodule

// File: tb/tb_spi_frame_sched.sv
module tb_spi_frame_sched;
   localparam int W  = 2;
   localparam int D  = 16;
   localparam int FW = W * D;

   logic       clk = 1'b0;
   logic       nrst;
   logic       flush;
   logic       clear_ovf;
   logic       busy;
   logic       overflow;
   logic [7:0] drop_count;

   int n_cmp = 0;
   int n_err = 0;

   spi_frame_sched_if #(.DATA_WIDTH(W), .DATA_DEPTH(D)) bus ();

   spi_frame_sched #(.DATA_WIDTH(W), .DATA_DEPTH(D)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .bus        (bus.slave),
      .flush      (flush),
      .clear_ovf  (clear_ovf),
      .busy       (busy),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   // Reference model: list of held frames (head = streaming), position in head frame, drop status.
   logic [FW-1:0] held[$];
   int            m_idx;
   bit            m_ovf;
   int            m_drops;

   task automatic model_reset();
      held.delete();
      m_idx   = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
   endtask

   task automatic model_step(input bit fv, input logic [FW-1:0] fd, input bit fl,
                             input bit clr, input bit rdy);
      bit dropped;
      dropped = 1'b0;
      if (fl) begin
         held.delete();
         m_idx = 0;
      end else begin
         if (held.size() > 0 && rdy) begin
            if (m_idx == D - 1) begin
               held.delete(0);
               m_idx = 0;
            end else begin
               m_idx++;
            end
         end
         if (fv) begin
            if (held.size() < 2) held.push_back(fd);
            else dropped = 1'b1;
         end
      end
      if (clr) begin
         m_ovf   = 1'b0;
         m_drops = 0;
      end
      if (dropped) begin
         m_ovf = 1'b1;
         if (m_drops < 255) m_drops++;
      end
   endtask

   function automatic int exp_drop_count();
`ifdef SPI_FRAME_SCHED_DROP_CNT_EN
      return m_drops;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [FW-1:0] sh;
      chk({tag, "_valid"}, 32'(bus.sym_valid), 32'(held.size() > 0));
      if (held.size() > 0) begin
         sh = held[0] >> (W * (D - 1 - m_idx));
         chk({tag, "_data"}, 32'(bus.sym_data), 32'(sh[W-1:0]));
      end
      chk({tag, "_index"}, 32'(bus.sym_index), 32'(m_idx));
      chk({tag, "_last"}, 32'(bus.sym_last), 32'(held.size() > 0 && m_idx == D - 1));
      chk({tag, "_busy"}, 32'(busy), 32'(held.size() > 0));
      chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, "_dropcnt"}, 32'(drop_count), 32'(exp_drop_count()));
   endtask

   task automatic cycle(input string tag, input bit fv, input logic [FW-1:0] fd,
                        input bit fl, input bit clr, input bit rdy);
      bus.frame_valid = fv;
      bus.frame_data  = fd;
      flush           = fl;
      clear_ovf       = clr;
      bus.sym_ready   = rdy;
      @(posedge clk);
      #1;
      model_step(fv, fd, fl, clr, rdy);
      check_all(tag);
   endtask

   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] f;
      f = '0;
      for (int i = 0; i < (FW + 31) / 32; i++) f = (f << 32) | FW'($urandom);
      return f;
   endfunction

   initial begin
      logic [FW-1:0] tp_frame;
      bit            reached;

      tp_frame        = 32'hE400_0000;
      nrst            = 1'b0;
      bus.frame_valid = 1'b0;
      bus.frame_data  = '0;
      bus.sym_ready   = 1'b1;
      flush           = 1'b0;
      clear_ovf       = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset_data", 32'(bus.sym_data), 32'd0);
      nrst = 1'b1;

      // Known frame, downstream always ready: 3,2,1,0 then zeros.
      cycle("tp1_load", 1'b1, tp_frame, 1'b0, 1'b0, 1'b1);
      chk("tp1_first_sym", 32'(bus.sym_data), 32'd3);
      for (int i = 0; i < D; i++) cycle("tp1", 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("tp1_idle_busy", 32'(busy), 32'd0);

      // Same frame with ready toggling: every symbol held while not ready.
      cycle("tp2_load", 1'b1, tp_frame, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2 * D + 2; i++) cycle("tp2", 1'b0, '0, 1'b0, 1'b0, (i % 2) == 0);
      chk("tp2_idle_busy", 32'(busy), 32'd0);

      // A, B, C on consecutive cycles: C finds pending occupied and is dropped.
      cycle("tp3_a", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      cycle("tp3_b", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      cycle("tp3_c", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      chk("tp3_overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < 2 * D + 2; i++) cycle("tp3", 1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Clear status, then a frame arriving on A's last transfer with pending full is accepted.
      cycle("tp4_clr", 1'b0, '0, 1'b0, 1'b1, 1'b1);
      chk("tp4_clr_ovf", 32'(overflow), 32'd0);
      cycle("tp4_a", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      cycle("tp4_b", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 64 && !reached; i++) begin
         if (held.size() == 2 && m_idx == D - 1) reached = 1'b1;
         else cycle("tp4_run", 1'b0, '0, 1'b0, 1'b0, 1'b1);
      end
      chk("tp4_reach_last", 32'(reached), 32'd1);
      cycle("tp4_c", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      chk("tp4_no_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 2 * D + 2; i++) cycle("tp4", 1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Flush at index 5 with pending full.
      cycle("tp5_a", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      cycle("tp5_b", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 32 && !reached; i++) begin
         if (m_idx == 5) reached = 1'b1;
         else cycle("tp5_run", 1'b0, '0, 1'b0, 1'b0, 1'b1);
      end
      chk("tp5_reach_5", 32'(reached), 32'd1);
      cycle("tp5_flush", 1'b1, rand_frame(), 1'b1, 1'b0, 1'b1);
      chk("tp5_flush_valid", 32'(bus.sym_valid), 32'd0);
      chk("tp5_flush_busy", 32'(busy), 32'd0);
      cycle("tp5_next", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      chk("tp5_next_index", 32'(bus.sym_index), 32'd0);
      for (int i = 0; i < D + 2; i++) cycle("tp5", 1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Saturation: fill both slots with ready low, then force 256 drops.
      cycle("tp6_a", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b0);
      cycle("tp6_b", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) cycle("tp6_drop", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b0);
`ifdef SPI_FRAME_SCHED_DROP_CNT_EN
      chk("tp6_saturated", 32'(drop_count), 32'd255);
`else
      chk("tp6_saturated", 32'(drop_count), 32'd0);
`endif
      cycle("tp6_clr_drop", 1'b1, rand_frame(), 1'b0, 1'b1, 1'b0);
      chk("tp6_clr_drop_ovf", 32'(overflow), 32'd1);
      cycle("tp6_clr", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("tp6_clr_ovf", 32'(overflow), 32'd0);
      cycle("tp6_flush", 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         cycle("rnd", ($urandom_range(0, 3) == 0), rand_frame(), ($urandom_range(0, 99) == 0),
               ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
      end

      // Asynchronous reset in the middle of a frame.
      cycle("tp7_a", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      cycle("tp7_b", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      cycle("tp7_c", 1'b1, rand_frame(), 1'b0, 1'b0, 1'b1);
      repeat (3) cycle("tp7_run", 1'b0, '0, 1'b0, 1'b0, 1'b1);
      #2;
      nrst = 1'b0;
      #1;
      model_reset();
      check_all("tp7_rst");
      chk("tp7_rst_data", 32'(bus.sym_data), 32'd0);
      chk("tp7_rst_valid", 32'(bus.sym_valid), 32'd0);
      #2;
      nrst = 1'b1;
      cycle("tp7_after", 1'b1, tp_frame, 1'b0, 1'b0, 1'b1);
      chk("tp7_after_sym", 32'(bus.sym_data), 32'd3);
      for (int i = 0; i < D; i++) cycle("tp7_tail", 1'b0, '0, 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/spi_frame_sched.md
# spi_frame_sched

Frame scheduler that sits downstream of the SPI receive datapath. It accepts each completed receive frame (a one-cycle valid pulse plus a DATA_WIDTH×DATA_DEPTH-bit word) and buffers up to two frames. It streams each frame out as DATA_DEPTH symbols of DATA_WIDTH bits over a valid/ready handshake, and drops and counts frames that arrive with no buffer space.

## Interface
Parameters:
- DATA_WIDTH, 2, bits per symbol
- DATA_DEPTH, 16, symbols per frame; must be ≥ 2

Ports:
- clk  in  1  system clock; all logic on the rising edge
- nrst  in  1  asynchronous active-low reset
- frame_valid  in  1  one-cycle pulse: frame_data holds a complete frame
- frame_data  in  DATA_WIDTH*DATA_DEPTH  received frame; sampled only when frame_valid=1
- flush  in  1  synchronous abort: discard the active and pending frames
- clear_ovf  in  1  synchronous clear of overflow and drop_count
- sym_ready  in  1  downstream accepts a symbol
- sym_valid  out  1  sym_data/sym_index/sym_last are valid
- sym_data  out  DATA_WIDTH  current symbol
- sym_index  out  $clog2(DATA_DEPTH)  position of the symbol within its frame, 0 first
- sym_last  out  1  sym_index == DATA_DEPTH-1
- busy  out  1  active or pending frame held
- overflow  out  1  sticky: at least one frame dropped
- drop_count  out  8  dropped frames, saturating

## Operation
- Storage is two frame registers, active and pending, with pending_vld.
- FSM has two states.
  - IDLE: no active frame; sym_valid=0.
  - STREAM: active frame held; sym_valid=1.
- Symbol order:
  - Symbol k = frame_data[W*D-1-W*k -: W], where W=DATA_WIDTH and D=DATA_DEPTH.
  - The MSB symbol goes first, matching the first-received bits of the shift register.
- Transfer: sym_valid & sym_ready. Each transfer advances sym_index by 1.
- On a transfer with sym_last=1:
  - If pending_vld (or a frame_valid arrives that cycle), that frame becomes active, sym_index=0, state stays STREAM.
  - Otherwise the state returns to IDLE.
- Frame arrival (frame_valid=1):
  - In IDLE: the frame loads into active; next state is STREAM.
  - In STREAM with pending empty: the frame loads into pending.
  - In STREAM with pending full and a last-symbol transfer in the same cycle: pending moves to active and the new frame loads into pending. The frame is accepted.
  - In STREAM with pending full and no last-symbol transfer: the frame is dropped, overflow←1, drop_count←drop_count+1 saturating at 255.
- flush:
  - Next state is IDLE, pending_vld←0, sym_index←0.
  - A frame_valid in the same cycle is discarded and not counted as a drop.
  - flush does not alter overflow or drop_count.
- clear_ovf: overflow←0, drop_count←0. In the same cycle as a drop, the drop wins: overflow=1, drop_count=1.
- busy = (state==STREAM) | pending_vld.
- Output stability: while sym_valid=1 and sym_ready=0, sym_data, sym_index and sym_last hold their values.

## Timing
- Reset values: sym_valid=0, sym_data=0, sym_index=0, sym_last=0, busy=0, overflow=0, drop_count=0. State is IDLE and pending_vld=0.
- Reset mid-frame discards all held data immediately (asynchronous).
- Latency: frame_valid in IDLE at cycle N gives sym_valid=1 with symbol 0 at N+1.
- Throughput:
  - With sym_ready held at 1, one symbol per cycle.
  - A full frame takes DATA_DEPTH cycles.
  - Back-to-back frames have no bubble: the last symbol of frame A at cycle M is followed by symbol 0 of frame B at M+1.
- Drop status is visible the cycle after the dropping frame_valid.
- All outputs are registered; there is no combinational path from sym_ready to sym_valid or sym_data.

## Configuration
- SPI_FRAME_SCHED_DROP_CNT_EN
  - Defined: the 8-bit saturating drop_count is implemented as described.
  - Undefined: drop_count is tied to 0; overflow and drop behaviour are otherwise unchanged.

## Test plan
- Reset, then frame_valid with frame_data=32'hE400_0000 and sym_ready=1 (defaults) -> sym_valid high the next cycle. The 16 symbols are 3,2,1,0 then 0×12, with sym_index 0..15 and sym_last only at index 15. Then IDLE and busy=0.
- Same frame with sym_ready toggling 1,0,1,0 -> each symbol held while sym_ready=0, exactly 16 transfers, no duplicates or skips.
- Three frames A, B, C pulsed on consecutive cycles while A is streaming with sym_ready=1 -> A and B stream with no bubble, C dropped. overflow=1 and drop_count=1 (0 if the macro is undefined).
- Pending full and frame_valid coincident with A's last-symbol transfer -> frame accepted, overflow stays 0, stream order A, B, new frame.
- flush asserted at sym_index=5 with pending full -> sym_valid=0 and busy=0 next cycle. The next frame starts at sym_index=0.
- 256 forced drops, then clear_ovf coincident with another drop -> drop_count saturates at 255, then reads 1 with overflow=1. Asserting nrst mid-stream zeroes all outputs immediately.
